// File: rtl/rv_pkg.sv
// rv_pkg: shared widths, opcodes, fetch FSM states and buffer entry type.
package rv_pkg;
    localparam int XLEN = 32;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    typedef enum logic [1:0] {FETCH, WAIT, DROP, HALT} fetch_state_t;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus.
interface fetch_unit_if;
    import rv_pkg::*;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rdata;
    modport master(output imem_req_valid, imem_addr, input imem_req_ready, imem_rsp_valid, imem_rdata);
    modport slave(input imem_req_valid, imem_addr, output imem_req_ready, imem_rsp_valid, imem_rdata);
endinterface

// File: rtl/fetch_unit_buf.sv
// fetch_buf: two-entry FIFO of {pc, instr} with synchronous flush.
module fetch_buf import rv_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_instr,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_instr,
    output logic [1:0]      count
);
    fetch_entry_t mem [DEPTH];
    logic rd_ptr, wr_ptr, do_pop;
    assign do_pop = pop && count != 2'd0;
    assign head_pc = mem[rd_ptr].pc;
    assign head_instr = mem[rd_ptr].instr;
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
                wr_ptr <= !wr_ptr;
            end
            if (do_pop) rd_ptr <= !rd_ptr;
            count <= count + {1'b0, push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher with redirect/drop handling and a 2-entry buffer.
module fetch_unit import rv_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    fetch_unit_if.master    imem,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7,
    output logic            misalign_err
);
    fetch_state_t state, state_nxt;
    logic [XLEN-1:0] pc, req_pc, head_pc, head_instr;
    logic [1:0] count;
    logic accept, push, pop, flush, mis, err_nxt;
    assign imem.imem_req_valid = !reset && state == FETCH && count < 2'(DEPTH);
    assign imem.imem_addr = pc;
    assign accept = imem.imem_req_valid && imem.imem_req_ready;
    assign flush = redirect && state != HALT;
    assign mis = flush && redirect_target[1:0] != 2'b00;
    assign err_nxt = misalign_err || mis;
    assign push = state == WAIT && imem.imem_rsp_valid && !redirect;
    assign instr_valid = !reset && count != 2'd0;
    assign pop = instr_valid && instr_ready;
    assign instr = instr_valid ? head_instr : '0;
    assign instr_pc = instr_valid ? head_pc : '0;
    assign op = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[30];
    // A sticky misalign means the pending response must drain before halting.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   state_nxt = flush ? (accept ? DROP : (mis ? HALT : FETCH)) : (accept ? WAIT : FETCH);
            WAIT:    state_nxt = !imem.imem_rsp_valid ? (flush ? DROP : WAIT) : (err_nxt ? HALT : FETCH);
            DROP:    state_nxt = imem.imem_rsp_valid ? (err_nxt ? HALT : FETCH) : DROP;
            default: state_nxt = HALT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc <= RESET_PC;
            req_pc <= '0;
            misalign_err <= 1'b0;
        end else begin
            state <= state_nxt;
            misalign_err <= err_nxt;
            if (flush) pc <= redirect_target;
            else if (accept) pc <= pc + 32'd4;
            if (accept) req_pc <= pc;
        end
    end
    fetch_buf #(.DEPTH(DEPTH)) u_buf (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .flush(flush),
        .push_pc(req_pc),
        .push_instr(imem.imem_rdata),
        .head_pc(head_pc),
        .head_instr(head_instr),
        .count(count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard plus redirect vector table for fetch_unit.
module tb_fetch_unit;
    import rv_pkg::*;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;
    typedef struct {
        logic [31:0] target;
        bit          same;
        bit          exp_err;
    } rd_vec_t;
    logic clk = 1'b0;
    logic reset, redirect, instr_ready, instr_valid, funct7, misalign_err;
    logic [31:0] redirect_target, instr, instr_pc;
    logic [6:0] op;
    logic [2:0] funct3;
    logic d2_valid, d2_f7, d2_err;
    logic [31:0] d2_instr, d2_pc;
    logic [6:0] d2_op;
    logic [2:0] d2_f3;
    int total, bad, lat, age;
    logic pend, d2_seen;
    logic [31:0] pend_addr;
    exp_t expq[$];
    logic [31:0] acc_q[$];
    logic [31:0] acc2_q[$];
    rd_vec_t tbl[5];
    fetch_unit_if bus();
    fetch_unit_if bus2();
    always #5 clk = ~clk;
    fetch_unit dut (
        .clk(clk), .reset(reset), .imem(bus), .redirect(redirect), .redirect_target(redirect_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .op(op), .funct3(funct3), .funct7(funct7), .misalign_err(misalign_err)
    );
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset), .imem(bus2), .redirect(1'b0), .redirect_target(32'h0),
        .instr_valid(d2_valid), .instr_ready(1'b1), .instr(d2_instr), .instr_pc(d2_pc),
        .op(d2_op), .funct3(d2_f3), .funct7(d2_f7), .misalign_err(d2_err)
    );
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [6:0] o;
        case (a[4:2])
            3'd0: o = OP_LOAD;
            3'd1: o = OP_STORE;
            3'd2: o = OP_RTYPE;
            3'd3: o = OP_BRANCH;
            3'd4: o = OP_ITYPE;
            3'd5: o = OP_JAL;
            3'd6: o = OP_LOAD;
            default: o = OP_RTYPE;
        endcase
        return {a[24:0], o};
    endfunction
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    task automatic cycle();
        logic acc, rsp_now, acc2;
        logic [31:0] a, a2, w;
        exp_t e;
        @(negedge clk);
        acc = bus.imem_req_valid && bus.imem_req_ready;
        a = bus.imem_addr;
        rsp_now = bus.imem_rsp_valid;
        acc2 = bus2.imem_req_valid && bus2.imem_req_ready;
        a2 = bus2.imem_addr;
        if (acc) acc_q.push_back(a);
        if (acc2) acc2_q.push_back(a2);
        if (instr_valid && instr_ready && expq.size() > 0) begin
            e = expq.pop_front();
            chk("instr_pc", instr_pc, e.pc);
            chk("instr", instr, e.word);
            chk("decode", 32'({funct7, funct3, op}), 32'({e.word[30], e.word[14:12], e.word[6:0]}));
        end
        if (d2_valid && !d2_seen) begin
            d2_seen = 1'b1;
            w = word_at(32'hFFFF_FFFC);
            chk("d2 pc", d2_pc, 32'hFFFF_FFFC);
            chk("d2 instr", d2_instr, w);
            chk("d2 decode", 32'({d2_f7, d2_f3, d2_op}), 32'({w[30], w[14:12], w[6:0]}));
        end
        @(posedge clk);
        #1;
        if (rsp_now) pend = 1'b0;
        if (acc) begin
            pend = 1'b1;
            pend_addr = a;
            age = 1;
        end else if (pend) age++;
        bus.imem_rsp_valid = pend && age >= lat;
        bus.imem_rdata = bus.imem_rsp_valid ? word_at(pend_addr) : '0;
        bus2.imem_rsp_valid = acc2;
        bus2.imem_rdata = acc2 ? word_at(a2) : '0;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        redirect = 1'b0;
        redirect_target = '0;
        expq.delete();
        pend = 1'b0;
        d2_seen = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rdata = '0;
        bus2.imem_rsp_valid = 1'b0;
        bus2.imem_rdata = '0;
        repeat (2) cycle();
        chk("rst req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst instr_valid", 32'(instr_valid), 32'd0);
        chk("rst instr", instr, 32'd0);
        chk("rst instr_pc", instr_pc, 32'd0);
        chk("rst misalign", 32'(misalign_err), 32'd0);
        reset = 1'b0;
        acc_q.delete();
        acc2_q.delete();
        #1;
        chk("first req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("first addr", bus.imem_addr, 32'd0);
    endtask
    task automatic drain(input int lim);
        int n;
        n = 0;
        while (expq.size() != 0 && n < lim) begin
            cycle();
            n++;
        end
        chk("drain left", 32'(expq.size()), 32'd0);
    endtask
    task automatic expect_run(input logic [31:0] base, input int cnt);
        for (int k = 0; k < cnt; k++) expq.push_back({base + 32'(4 * k), word_at(base + 32'(4 * k))});
    endtask
    initial begin
        int n;
        total = 0;
        bad = 0;
        lat = 1;
        age = 0;
        pend_addr = '0;
        instr_ready = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus2.imem_req_ready = 1'b1;
        tbl[0] = '{target: 32'h0000_0100, same: 1'b0, exp_err: 1'b0};
        tbl[1] = '{target: 32'h0000_0200, same: 1'b1, exp_err: 1'b0};
        tbl[2] = '{target: 32'h0000_0102, same: 1'b0, exp_err: 1'b1};
        tbl[3] = '{target: 32'h0000_0103, same: 1'b1, exp_err: 1'b1};
        tbl[4] = '{target: 32'hFFFF_FFF8, same: 1'b0, exp_err: 1'b0};
        do_reset();
        expect_run(32'h0, 3);
        drain(40);
        chk("acc count", 32'(acc_q.size() >= 3), 32'd1);
        if (acc_q.size() >= 3) for (int k = 0; k < 3; k++) chk("acc addr", acc_q[k], 32'(4 * k));
        chk("d2 acc count", 32'(acc2_q.size() >= 2), 32'd1);
        if (acc2_q.size() >= 2) begin
            chk("d2 addr0", acc2_q[0], 32'hFFFF_FFFC);
            chk("d2 addr1", acc2_q[1], 32'h0000_0000);
        end
        chk("d2 seen", 32'(d2_seen), 32'd1);
        chk("d2 misalign", 32'(d2_err), 32'd0);
        do_reset();
        instr_ready = 1'b0;
        repeat (10) cycle();
        chk("full req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("full instr_valid", 32'(instr_valid), 32'd1);
        chk("full head pc", instr_pc, 32'h0);
        chk("full req count", 32'(acc_q.size()), 32'd2);
        expect_run(32'h0, 4);
        instr_ready = 1'b1;
        drain(40);
        do_reset();
        redirect = 1'b1;
        redirect_target = 32'h400;
        cycle();
        redirect = 1'b0;
        acc_q.delete();
        expect_run(32'h400, 2);
        drain(40);
        chk("fetch redir addr", acc_q.size() > 0 ? acc_q[0] : 32'hDEAD_BEEF, 32'h400);
        do_reset();
        instr_ready = 1'b0;
        repeat (6) cycle();
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_target = 32'h500;
        cycle();
        redirect = 1'b0;
        acc_q.delete();
        expect_run(32'h500, 2);
        drain(40);
        chk("flush redir addr", acc_q.size() > 0 ? acc_q[0] : 32'hDEAD_BEEF, 32'h500);
        for (int i = 0; i < 5; i++) begin
            lat = 3;
            do_reset();
            n = 0;
            while (acc_q.size() == 0 && n < 10) begin
                cycle();
                n++;
            end
            if (tbl[i].same) begin
                n = 0;
                while (!bus.imem_rsp_valid && n < 10) begin
                    cycle();
                    n++;
                end
            end
            expq.delete();
            redirect = 1'b1;
            redirect_target = tbl[i].target;
            cycle();
            redirect = 1'b0;
            acc_q.delete();
            if (!tbl[i].exp_err) begin
                expect_run(tbl[i].target, 3);
                drain(80);
                chk("redir addr", acc_q.size() > 0 ? acc_q[0] : 32'hDEAD_BEEF, tbl[i].target);
                chk("redir misalign", 32'(misalign_err), 32'd0);
            end else begin
                repeat (20) cycle();
                chk("halt misalign", 32'(misalign_err), 32'd1);
                chk("halt req count", 32'(acc_q.size()), 32'd0);
                chk("halt req_valid", 32'(bus.imem_req_valid), 32'd0);
                chk("halt instr_valid", 32'(instr_valid), 32'd0);
                do_reset();
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: DEPTH, default 2, instruction buffer entries; only the value 2 is supported.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 imem_req_valid  out  1  fetch request to instruction memory.
REQ-006 imem_req_ready  in  1  memory accepts the request this cycle.
REQ-007 imem_addr  out  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  in  1  read data valid; arrives at least 1 cycle after acceptance.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 redirect  in  1  taken branch/jump (PCSrc from control_unit).
REQ-011 redirect_target  in  32  new PC when redirect=1.
REQ-012 instr_valid  out  1  buffer head holds a valid instruction.
REQ-013 instr_ready  in  1  decode stage consumes the head this cycle.
REQ-014 instr  out  32  head instruction word.
REQ-015 instr_pc  out  32  PC of the head instruction.
REQ-016 Op / funct3 / funct7  out  7 / 3 / 1  instr[6:0], instr[14:12], instr[30], feeding control_unit.
REQ-017 misalign_err  out  1  sticky flag: a redirect target had bits [1:0] nonzero.

Function
REQ-018 FSM states: FETCH, WAIT, DROP, HALT.
REQ-019 FETCH: imem_req_valid=1 only if buffer count < 2; on valid&&ready, pc <= pc+4, go to WAIT.
REQ-020 FETCH with buffer count = 2: imem_req_valid=0; stay in FETCH.
REQ-021 At most one request is outstanding at any time.
REQ-022 WAIT: on imem_rsp_valid, push {pc_of_request, imem_rdata} into the buffer; go to FETCH.
REQ-023 Push in WAIT never sees a full buffer, because a request is issued only when count < 2.
REQ-024 Handshake: the head pops when instr_valid && instr_ready.
REQ-025 Push and pop in the same cycle keep count unchanged.
REQ-026 Redirect (aligned target), any non-HALT state:
  - flush the buffer; count <= 0
  - pc <= redirect_target
  - a pop in the same cycle still counts as consumed
REQ-027 Redirect in WAIT with no response that cycle: go to DROP.
REQ-028 Redirect in WAIT with a response in the same cycle: discard the response; go to FETCH.
REQ-029 DROP: imem_req_valid=0; discard the next response, then go to FETCH.
REQ-030 DROP: a further redirect updates pc only.
REQ-031 Redirect in FETCH while a request is being accepted that cycle: go to DROP; the accepted request's address is not used.
REQ-032 Redirect with target[1:0] != 0:
  - misalign_err <= 1
  - flush the buffer
  - go to HALT if no request is outstanding
  - otherwise go to DROP, then HALT
REQ-033 HALT: no requests; instr_valid=0; cleared only by reset.
REQ-034 imem_addr = pc in every state; PC arithmetic is modulo 2^32 (0xFFFF_FFFC+4 wraps to 0).
REQ-035 instr_valid is driven only by buffer count; no combinational path from imem_rdata to instr.

Reset
REQ-036 On reset:
  - pc <= RESET_PC; state <= FETCH; count <= 0; misalign_err <= 0
  - imem_req_valid=0 during the reset cycle
  - the first request is issued the cycle after reset falls
REQ-037 Reset mid-WAIT: any late response after reset is ignored; the memory is required to drop pending reads on reset.
REQ-038 Outputs in reset: instr_valid=0, instr=0, instr_pc=0.

Structure
REQ-039 Shared package rv_pkg holds:
  - the FSM state enum
  - opcode constants (LOAD 0000011, STORE 0100011, RTYPE 0110011, BRANCH 1100011, ITYPE 0010011, JAL 1101111)
  - XLEN=32
REQ-040 Sub-module fetch_buf: 2-entry FIFO of {pc, instr} with push/pop/flush and count output.

Verification
REQ-041 Reset release, ready=1, rsp 1 cycle later, instr_ready=1 -> addresses 0,4,8; instr_pc sequence 0,4,8; Op matches imem_rdata[6:0].
REQ-042 instr_ready=0 for 10 cycles -> exactly 2 instructions buffered; imem_req_valid=0; no response lost.
REQ-043 Redirect to 0x100 while in WAIT -> next response dropped; next request addr=0x100; instr_pc=0x100.
REQ-044 Redirect to 0x200 in the same cycle as a response -> response discarded; next request addr=0x200.
REQ-045 Redirect to 0x102 -> misalign_err=1; no further requests until reset; reset clears the flag.
REQ-046 RESET_PC=0xFFFF_FFFC -> second fetch addr=0x0000_0000.
